// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_param
// Description : Parametrised sequential shift-add multiplier. Operands are
//               WIDTH bits wide and are either unsigned or two's complement,
//               selected per operation. One partial-product bit is processed
//               per clock. The 2*WIDTH-bit product is held until the next
//               operation completes.
// Revision    : 1.0 - initial release (WIDTH generalisation, sign mode, busy)
// ============================================================================
module mult_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,     // asynchronous, active-low
    input  logic                 init,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only has to reach WIDTH-1, which identifies the last RUN edge.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc;       // running sum of partial products
    logic [2*WIDTH-1:0] mcand;     // multiplicand magnitude, shifted left
    logic [WIDTH-1:0]   mplier;    // multiplier magnitude, shifted right
    logic [CNT_W-1:0]   cnt;       // number of RUN edges already taken
    logic               neg;       // product must be negated at the end

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic [2*WIDTH-1:0] add_term;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result;
    logic               last_iter;

    // Operand magnitudes and result sign, evaluated at the sampling edge.
    // The negation of the most negative value wraps back to 2^(WIDTH-1),
    // which is exactly its magnitude when read as unsigned.
    always_comb begin
        mag_a  = (sgn && A[WIDTH-1]) ? (-A) : A;
        mag_b  = (sgn && B[WIDTH-1]) ? (-B) : B;
        neg_in = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
    end

    // One shift-add step; the final product is the sign-corrected last sum.
    // A zero magnitude negates to zero, so no -0 special case is needed.
    always_comb begin
        add_term  = mplier[0] ? mcand : '0;
        acc_sum   = acc + add_term;
        result    = neg ? (-acc_sum) : acc_sum;
        last_iter = (cnt == LAST_CNT);
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // init is deliberately ignored here; a new request must be
                // presented while IDLE.
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath sequencing
    // ------------------------------------------------------------------------
    // Operand capture in IDLE, shift-add iterations in RUN, product update on
    // the last RUN edge. pp is touched nowhere else, so it holds its value
    // through IDLE, DONE and the whole of the following operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            pp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        cnt    <= '0;
                        neg    <= neg_in;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        pp <= result;
                    end
                end
                default: begin
                    // DONE: datapath idles while the result is flagged.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
